seq_mult_core: RTL and testbench
================================

# seq_mult_core

Parametrised sequential shift-add multiplier core: accepts a WIDTH_M-bit multiplicand and a WIDTH_Q-bit multiplier on a start pulse and iterates one multiplier bit per clock. Each iteration is a registered add with a carry flip-flop followed by a right shift. The core reports busy and done and holds the WIDTH_M+WIDTH_Q-bit product until the next completion. It replaces the free-standing adder in the multiplier datapath and sits between the operand registers and the result bus. An optional two's-complement mode is compiled in by macro.

## Interface
- WIDTH_M, 16: multiplicand width; must be ≥2.
- WIDTH_Q, 16: multiplier width (iteration count); must be ≥2.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request; accepted only in IDLE.
- multiplicand  in  WIDTH_M  operand M; sampled on accept.
- multiplier  in  WIDTH_Q  operand Q; sampled on accept.
- signed_mode  in  1  present only with SEQ_MULT_SIGNED_EN; sampled on accept.
- busy  out  1  high in CALC and DONE.
- done  out  1  one-cycle completion pulse.
- product  out  WIDTH_M+WIDTH_Q  registered result; {A,Q} at completion.

## Operation
- Internal registers: M (WIDTH_M), A (WIDTH_M), C (1), Q (WIDTH_Q), cnt ($clog2(WIDTH_Q+1)), and a latched signed flag.
- States: IDLE, CALC, DONE.
- IDLE with start=1: load M, Q and the signed flag; clear A and C; set cnt=WIDTH_Q; next state is CALC. With start=0, remain in IDLE.
- CALC, per cycle:
  - If Q[0]=1: {C,A} = A+M (WIDTH_M+1-bit sum, C is the true carry out). Otherwise {C,A} = {0,A}.
  - Then shift {C,A,Q} right by 1, and decrement cnt.
  - When cnt==1 during this cycle, next state is DONE.
- CALC→DONE edge: product ← resulting {A,Q}.
- DONE: done=1 for exactly this cycle; next state is IDLE unconditionally.
- start in CALC or DONE is ignored and not queued. Operand changes after accept have no effect.
- product holds its value through IDLE and the next CALC. It changes only on a CALC→DONE edge or on reset.
- Unsigned product is exact, with no overflow: result = M×Q mod 2^(WIDTH_M+WIDTH_Q).
- rst=1, taking precedence over everything including mid-CALC:
  - state ← IDLE; A, C, Q, M, cnt ← 0; product ← 0.
  - done and busy are low on the following cycle. The operation in flight is discarded.
- Reset values: busy=0, done=0, product=0.

## Timing
- Accept at edge k.
- CALC occupies cycles k+1 … k+WIDTH_Q.
- DONE is cycle k+WIDTH_Q+1: done=1 and the new product is visible.
- IDLE at k+WIDTH_Q+2; the earliest next accept is that edge.
- Start-to-done latency is WIDTH_Q+1 cycles. Throughput is one result per WIDTH_Q+2 cycles.
- busy rises the cycle after accept and falls together with done.
- Latency does not depend on operand values or on mode.

## Configuration
- SEQ_MULT_SIGNED_EN defined:
  - The signed_mode port exists.
  - With the latched flag=1, M and Q are two's complement. The add is sign-extended, {C,A} = sext(A)+sext(M), so C holds the sign bit, and the shift is arithmetic (C replicates).
  - In the final CALC cycle (cnt==1), Q[0]=1 subtracts M instead of adding it.
  - product is the exact two's-complement M×Q.
  - With flag=0, behaviour is identical to the unsigned core.
- Not defined: the port is absent and operation is unsigned only. Timing is identical in both builds.

## Test plan
All scenarios use defaults 16/16.
- 0xFFFF×0xFFFF, start at edge k → busy=1 for cycles k+1…k+17; done=1 only at k+17; product=0xFFFE0001.
- 0x8000×0x0003 (exercises carry) → product=0x00018000. 0x1234×0x0000 → 0x00000000; the previous product is held until DONE.
- start held high continuously with ops 3×5 then 7×9 → second accept at k+18; products 0x0000000F then 0x0000003F. Operands changed during CALC are ignored.
- rst pulsed at the 5th CALC cycle of 0xABCD×0x1234 → next cycle busy=0, done=0, product=0, and no done pulse follows. A fresh 2×3 then yields 0x00000006.
- SEQ_MULT_SIGNED_EN, signed_mode=1:
  - 0xFFFE×0x0003 → 0xFFFFFFFA.
  - 0x8000×0x8000 → 0x40000000.
  - 0x7FFF×0x8000 → 0xC0008000.
  - The same operands with signed_mode=0 → unsigned results.
- Back-to-back: start asserted during the DONE cycle → ignored; an accept in the following IDLE cycle succeeds and latency is again 17 cycles.

Source files
------------

// File: rtl/seq_mult_core.sv
// seq_mult_core: shift-add multiplier, one multiplier bit per clock. SEQ_MULT_SIGNED_EN adds two's-complement mode.
// Latency: start accept to done pulse is WIDTH_Q+1 cycles; product updates on the CALC->DONE edge.
// Backpressure: none; start is taken only in IDLE, and start in CALC or DONE is dropped, not queued.
module seq_mult_core #(
  parameter int WIDTH_M = 16,
  parameter int WIDTH_Q = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [WIDTH_M-1:0]         multiplicand,
  input  logic [WIDTH_Q-1:0]         multiplier,
`ifdef SEQ_MULT_SIGNED_EN
  input  logic                       signed_mode,
`endif
  output logic                       busy,
  output logic                       done,
  output logic [WIDTH_M+WIDTH_Q-1:0] product
);

  localparam int CW = $clog2(WIDTH_Q + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state_q, state_d;
  logic [WIDTH_M-1:0]   m_q, a_q, a_d;
  logic                 c_q, c_d;
  logic [WIDTH_Q-1:0]   q_q, q_d;
  logic [CW-1:0]        cnt_q;
  logic                 sgn_q;
  logic                 accept, last;
  logic [WIDTH_M:0]     m_ext, sum;

  assign accept = (state_q == IDLE) && start;
  assign last   = (cnt_q == CW'(1));
  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (last)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // {c_q,a_q} is already the sign-extended A in signed mode (C replicates on
  // each shift) and a zero-extended A otherwise, so one adder serves both.
  always_comb begin
    m_ext = {sgn_q & m_q[WIDTH_M-1], m_q};
    if (!q_q[0])            sum = {c_q, a_q};
    else if (sgn_q && last) sum = {c_q, a_q} - m_ext;
    else                    sum = {c_q, a_q} + m_ext;
    c_d = sgn_q & sum[WIDTH_M];
    a_d = sum[WIDTH_M:1];
    q_d = {sum[0], q_q[WIDTH_Q-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_q     <= '0;
      a_q     <= '0;
      c_q     <= 1'b0;
      q_q     <= '0;
      cnt_q   <= '0;
      product <= '0;
    end else if (accept) begin
      m_q   <= multiplicand;
      a_q   <= '0;
      c_q   <= 1'b0;
      q_q   <= multiplier;
      cnt_q <= CW'(WIDTH_Q);
    end else if (state_q == CALC) begin
      a_q   <= a_d;
      c_q   <= c_d;
      q_q   <= q_d;
      cnt_q <= cnt_q - CW'(1);
      if (last) product <= {a_d, q_d};
    end
  end

`ifdef SEQ_MULT_SIGNED_EN
  always_ff @(posedge clk) begin
    if (rst)         sgn_q <= 1'b0;
    else if (accept) sgn_q <= signed_mode;
  end
`else
  assign sgn_q = 1'b0;
`endif

endmodule

// File: tb/tb_seq_mult_core.sv
// tb_seq_mult_core: directed vectors with hand-computed products, latency and busy/done timing.
// Build with SEQ_MULT_SIGNED_EN defined to also cover the two's-complement vectors.
module tb_seq_mult_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] multiplicand;
  logic [15:0] multiplier;
  logic        sgn_in;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_mult_core #(.WIDTH_M(16), .WIDTH_Q(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
`ifdef SEQ_MULT_SIGNED_EN
    .signed_mode  (sgn_in),
`endif
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete operation: accept, watch busy/done and the held product, check the result.
  task automatic mult(input string tag, input logic [15:0] m, input logic [15:0] q,
                      input logic sm, input logic [31:0] hold, input logic [31:0] exp);
    int lat;
    int bad_busy;
    int bad_hold;
    multiplicand = m;
    multiplier   = q;
    sgn_in       = sm;
    start        = 1'b1;
    step();
    start    = 1'b0;
    lat      = 1;
    bad_busy = 0;
    bad_hold = 0;
    while (!done && lat < 40) begin
      if (!busy) bad_busy++;
      if (product !== hold) bad_hold++;
      step();
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd17);
    chk({tag, "_busy_calc"}, 64'(bad_busy), 64'd0);
    chk({tag, "_hold"}, 64'(bad_hold), 64'd0);
    chk({tag, "_busy_done"}, 64'(busy), 64'd1);
    chk({tag, "_product"}, 64'(product), 64'(exp));
    step();
    chk({tag, "_idle"}, 64'({busy, done}), 64'd0);
  endtask

  initial begin
    int cnt;
    rst          = 1'b1;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    sgn_in       = 1'b0;
    step();
    step();
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_product", 64'(product), 64'd0);
    rst = 1'b0;
    step();

    mult("ffff_x_ffff", 16'hFFFF, 16'hFFFF, 1'b0, 32'h0, 32'hFFFE0001);
    mult("carry", 16'h8000, 16'h0003, 1'b0, 32'hFFFE0001, 32'h00018000);
    mult("zero", 16'h1234, 16'h0000, 1'b0, 32'h00018000, 32'h00000000);

    // start held high; operands swapped during the first CALC
    multiplicand = 16'd3;
    multiplier   = 16'd5;
    start        = 1'b1;
    step();
    multiplicand = 16'd7;
    multiplier   = 16'd9;
    cnt = 1;
    while (!done && cnt < 40) begin
      step();
      cnt++;
    end
    chk("held_first_latency", 64'(cnt), 64'd17);
    chk("held_first_product", 64'(product), 64'h0F);
    step();
    chk("held_idle_gap", 64'(busy), 64'd0);
    step();
    chk("held_second_accept", 64'(busy), 64'd1);
    start = 1'b0;
    cnt = 1;
    while (!done && cnt < 40) begin
      step();
      cnt++;
    end
    chk("held_second_latency", 64'(cnt), 64'd17);
    chk("held_second_product", 64'(product), 64'h3F);
    step();

    // reset during the 5th CALC cycle
    multiplicand = 16'hABCD;
    multiplier   = 16'h1234;
    start        = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_product", 64'(product), 64'd0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) cnt++;
      step();
    end
    chk("midrst_no_done", 64'(cnt), 64'd0);
    mult("after_rst", 16'd2, 16'd3, 1'b0, 32'h0, 32'h00000006);

`ifdef SEQ_MULT_SIGNED_EN
    mult("s_neg2_x_3", 16'hFFFE, 16'h0003, 1'b1, 32'h00000006, 32'hFFFFFFFA);
    mult("s_min_x_min", 16'h8000, 16'h8000, 1'b1, 32'hFFFFFFFA, 32'h40000000);
    mult("s_max_x_min", 16'h7FFF, 16'h8000, 1'b1, 32'h40000000, 32'hC0008000);
    mult("u_fffe_x_3", 16'hFFFE, 16'h0003, 1'b0, 32'hC0008000, 32'h0002FFFA);
    mult("u_8000_x_8000", 16'h8000, 16'h8000, 1'b0, 32'h0002FFFA, 32'h40000000);
    mult("u_7fff_x_8000", 16'h7FFF, 16'h8000, 1'b0, 32'h40000000, 32'h3FFF8000);
`endif

    // start raised in the DONE cycle is dropped; the next IDLE cycle accepts
    multiplicand = 16'd4;
    multiplier   = 16'd4;
    start        = 1'b1;
    step();
    start = 1'b0;
    cnt = 1;
    while (!done && cnt < 40) begin
      step();
      cnt++;
    end
    chk("b2b_first_product", 64'(product), 64'h10);
    multiplicand = 16'd6;
    multiplier   = 16'd7;
    start        = 1'b1;
    step();
    chk("b2b_done_ignored", 64'(busy), 64'd0);
    step();
    start = 1'b0;
    chk("b2b_accept", 64'(busy), 64'd1);
    cnt = 1;
    while (!done && cnt < 40) begin
      step();
      cnt++;
    end
    chk("b2b_latency", 64'(cnt), 64'd17);
    chk("b2b_product", 64'(product), 64'd42);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
